// File: rtl/cdc_word_receiver.sv
// Destination-side end of a two-phase req/ack word transfer. It captures the held
// source word once a request is seen, presents it with valid/ready, and returns an ack toggle.
module cdc_word_receiver #(
  parameter int WORD_WIDTH    = 36,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req_synced,
  input  logic [WORD_WIDTH-1:0] data_from,
  output logic                  ack_to_source,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  valid,
  input  logic                  ready
);

  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic                    valid_q, valid_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;
  logic                    pending;

  assign pending = (req_synced != ack_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pending) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!valid_q || ready) begin
          // A capture with ready=1 reloads the slot, so valid stays high.
          data_d  = data_from;
          valid_d = 1'b1;
          ack_d   = ~ack_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign ack_to_source = ack_q;
  assign data_out      = data_q;
  assign valid         = valid_q;

endmodule
